// File: rtl/alu_calc_pkg.sv
// Shared encodings for the execute-stage ALU slice: operation selects and operand mux codes.
// No logic of its own; imported by alu_core and alu_calculations.
package alu_calc_pkg;

    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_SLL  = 3'b110;
    localparam logic [2:0] OP_SRA  = 3'b111;

    localparam logic [1:0] SRCA_A    = 2'b00;
    localparam logic [1:0] SRCA_IMM  = 2'b01;
    localparam logic [1:0] SRCA_PC   = 2'b10;
    localparam logic [1:0] SRCA_ZERO = 2'b11;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_INC   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: op(srcA, srcB) -> result plus zero/negative flags.
// Latency 0; no flow control, result follows inputs continuously.
module alu_core
    import alu_calc_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_src_a,
    input  logic [WIDTH-1:0] i_src_b,
    input  logic [2:0]       i_op,
    output logic [WIDTH-1:0] o_result,
    output logic             o_zero,
    output logic             o_negative
);

    localparam int SHW = $clog2(WIDTH);

    logic [SHW-1:0] w_shamt;

    // Shift amount takes only the low bits of srcB; the rest are ignored.
    assign w_shamt = i_src_b[SHW-1:0];

    always_comb begin
        o_result = '0;
        case (i_op)
            OP_PASS: o_result = i_src_b;
            OP_ADD:  o_result = i_src_a + i_src_b;
            OP_SUB:  o_result = i_src_a - i_src_b;
            OP_AND:  o_result = i_src_a & i_src_b;
            OP_OR:   o_result = i_src_a | i_src_b;
            OP_XOR:  o_result = i_src_a ^ i_src_b;
            OP_SLL:  o_result = i_src_a << w_shamt;
            OP_SRA:  o_result = WIDTH'($signed(i_src_a) >>> w_shamt);
            default: o_result = '0;
        endcase
    end

    assign o_zero     = (o_result == '0);
    assign o_negative = o_result[WIDTH-1];

endmodule

// File: rtl/alu_calculations.sv
// Execute-stage slice: operand muxes, ALU, ALUOut register and live/held output select.
// Latency 0 (PCSrc=0) or 1 cycle (PCSrc=1); no backpressure, ALUOut reloads every edge.
module alu_calculations
    import alu_calc_pkg::*;
#(
    parameter int               WIDTH  = 16,
    parameter logic [WIDTH-1:0] PC_INC = 16'd2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] input_A,
    input  logic [WIDTH-1:0] input_B,
    input  logic [WIDTH-1:0] input_PC,
    input  logic [WIDTH-1:0] input_imm,
    input  logic [2:0]       input_ALUOp,
    input  logic [1:0]       input_ALUSrcA,
    input  logic [1:0]       input_ALUSrcB,
    input  logic             input_PCSrc,
    output logic [WIDTH-1:0] output_ALU,
    output logic             output_Zero,
    output logic             output_negative
);

    logic [WIDTH-1:0] w_src_a;
    logic [WIDTH-1:0] w_src_b;
    logic [WIDTH-1:0] w_result;
    logic [WIDTH-1:0] r_alu_out;

    always_comb begin
        w_src_a = '0;
        case (input_ALUSrcA)
            SRCA_A:    w_src_a = input_A;
            SRCA_IMM:  w_src_a = input_imm;
            SRCA_PC:   w_src_a = input_PC;
            SRCA_ZERO: w_src_a = '0;
            default:   w_src_a = '0;
        endcase
    end

    // The shifted immediate is the word-aligned branch offset.
    always_comb begin
        w_src_b = '0;
        case (input_ALUSrcB)
            SRCB_B:     w_src_b = input_B;
            SRCB_IMM:   w_src_b = input_imm;
            SRCB_INC:   w_src_b = PC_INC;
            SRCB_IMMSH: w_src_b = {input_imm[WIDTH-2:0], 1'b0};
            default:    w_src_b = '0;
        endcase
    end

    alu_core #(
        .WIDTH(WIDTH)
    ) u_alu_core (
        .i_src_a   (w_src_a),
        .i_src_b   (w_src_b),
        .i_op      (input_ALUOp),
        .o_result  (w_result),
        .o_zero    (output_Zero),
        .o_negative(output_negative)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_alu_out <= '0;
        end else begin
            r_alu_out <= w_result;
        end
    end

    assign output_ALU = input_PCSrc ? r_alu_out : w_result;

endmodule

// File: tb/tb_alu_calculations.sv
// Self-checking bench for alu_calculations: directed scenarios plus randomized traffic
// compared each cycle against a behavioural model of the execute stage.
module tb_alu_calculations;

    logic        clk;
    logic        reset;
    logic [15:0] input_A, input_B, input_PC, input_imm;
    logic [2:0]  input_ALUOp;
    logic [1:0]  input_ALUSrcA, input_ALUSrcB;
    logic        input_PCSrc;
    logic [15:0] output_ALU;
    logic        output_Zero, output_negative;

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] model_q = 16'h0000;

    alu_calculations dut (
        .clk            (clk),
        .reset          (reset),
        .input_A        (input_A),
        .input_B        (input_B),
        .input_PC       (input_PC),
        .input_imm      (input_imm),
        .input_ALUOp    (input_ALUOp),
        .input_ALUSrcA  (input_ALUSrcA),
        .input_ALUSrcB  (input_ALUSrcB),
        .input_PCSrc    (input_PCSrc),
        .output_ALU     (output_ALU),
        .output_Zero    (output_Zero),
        .output_negative(output_negative)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural reference: operand selection then the operation, in plain arithmetic.
    function automatic logic [15:0] ref_r(input logic [15:0] a, input logic [15:0] b,
                                          input logic [15:0] pc, input logic [15:0] imm,
                                          input logic [2:0] op, input logic [1:0] sa,
                                          input logic [1:0] sb);
        logic [15:0] x, y;
        int          n;
        logic [31:0] sum;
        x = (sa == 2'd0) ? a : (sa == 2'd1) ? imm : (sa == 2'd2) ? pc : 16'h0000;
        y = (sb == 2'd0) ? b : (sb == 2'd1) ? imm : (sb == 2'd2) ? 16'd2 : 16'(imm * 2);
        n = int'(y % 16);
        case (op)
            3'd0: return y;
            3'd1: begin sum = 32'(x) + 32'(y); return sum[15:0]; end
            3'd2: begin sum = 32'h10000 + 32'(x) - 32'(y); return sum[15:0]; end
            3'd3: return x & y;
            3'd4: return x | y;
            3'd5: return x ^ y;
            3'd6: begin sum = 32'(x) * (32'd1 << n); return sum[15:0]; end
            default: begin
                sum = 32'(x >> n);
                if (x[15]) sum = sum | (32'hFFFF & ~(32'hFFFF >> n));
                return sum[15:0];
            end
        endcase
    endfunction

    function automatic logic [15:0] cur_r();
        return ref_r(input_A, input_B, input_PC, input_imm, input_ALUOp,
                     input_ALUSrcA, input_ALUSrcB);
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ALUOut model: clears asynchronously, otherwise captures the live result each edge.
    always @(negedge reset) model_q = 16'h0000;
    always @(posedge clk) begin
        if (!reset) model_q = 16'h0000;
        else        model_q = cur_r();
    end

    // Per-cycle comparison, sampled on the falling edge.
    always @(negedge clk) begin
        logic [15:0] r;
        r = cur_r();
        check("cyc_alu",  output_ALU, input_PCSrc ? model_q : r);
        check("cyc_zero", {15'd0, output_Zero}, {15'd0, r == 16'h0000});
        check("cyc_neg",  {15'd0, output_negative}, {15'd0, r[15]});
    end

    task automatic drive(input logic pcsrc, input logic [1:0] sa, input logic [1:0] sb,
                         input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] pc, input logic [15:0] imm);
        input_PCSrc = pcsrc; input_ALUSrcA = sa; input_ALUSrcB = sb; input_ALUOp = op;
        input_A = a; input_B = b; input_PC = pc; input_imm = imm;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b1, 2'd0, 2'd0, 3'd1, 16'h1234, 16'h1111, 16'h0000, 16'h0000);
        #3;
        check("reset_out", output_ALU, 16'h0000);
        next_cycle();
        check("reset_hold", output_ALU, 16'h0000);
        #1 reset = 1'b1;

        // Pin the model itself against hand-computed values.
        check("model_add", ref_r(16'h0, 16'h5678, 16'hABCD, 16'h0, 3'd1, 2'd2, 2'd0), 16'h0245);
        check("model_sra", ref_r(16'h8001, 16'h0004, 16'h0, 16'h0, 3'd7, 2'd0, 2'd0), 16'hF800);
        check("model_bro", ref_r(16'h0, 16'h0, 16'h0, 16'hC003, 3'd0, 2'd3, 2'd3), 16'h8006);

        next_cycle();
        drive(1'b0, 2'd2, 2'd0, 3'd1, 16'h0000, 16'h5678, 16'hABCD, 16'h0000);
        #1;
        check("s1_add_wrap", output_ALU, 16'h0245);
        check("s1_flags", {14'd0, output_Zero, output_negative}, 16'h0000);

        next_cycle();
        drive(1'b1, 2'd0, 2'd1, 3'd2, 16'hABCD, 16'h0000, 16'h0000, 16'h1111);
        #1;
        check("held_0245", output_ALU, 16'h0245);
        check("s2_neg", {14'd0, output_Zero, output_negative}, 16'h0001);
        next_cycle();
        check("held_9abc", output_ALU, 16'h9ABC);

        drive(1'b0, 2'd1, 2'd0, 3'd3, 16'h0000, 16'h5555, 16'h0000, 16'h0F0F);
        #1;
        check("s3_and", output_ALU, 16'h0505);

        next_cycle();
        drive(1'b0, 2'd0, 2'd0, 3'd2, 16'h1234, 16'h1234, 16'h0000, 16'h0000);
        #1;
        check("s4_sub_zero", output_ALU, 16'h0000);
        check("s4_zero_flag", {15'd0, output_Zero}, 16'h0001);
        next_cycle();
        input_ALUOp = 3'd0; input_ALUSrcB = 2'd2;
        #1;
        check("s4_pass_inc", output_ALU, 16'h0002);

        next_cycle();
        drive(1'b0, 2'd0, 2'd0, 3'd6, 16'h8001, 16'h0004, 16'h0000, 16'h0000);
        #1;
        check("sll", output_ALU, 16'h0010);
        next_cycle();
        input_ALUOp = 3'd7;
        #1;
        check("sra", output_ALU, 16'hF800);
        next_cycle();
        input_B = 16'hFFF4;
        #1;
        check("sra_shamt_low", output_ALU, 16'hF800);

        // Mid-cycle reset with the held value selected.
        next_cycle();
        drive(1'b1, 2'd2, 2'd0, 3'd1, 16'h0000, 16'h5678, 16'hABCD, 16'h0000);
        next_cycle();
        check("pre_reset", output_ALU, 16'h0245);
        #1 reset = 1'b0;
        #1;
        check("async_clear", output_ALU, 16'h0000);
        check("flags_in_reset", {15'd0, output_Zero}, 16'h0000);
        next_cycle();
        check("reset_held_edge", output_ALU, 16'h0000);
        #1 reset = 1'b1;
        #1;
        check("released_pre_edge", output_ALU, 16'h0000);
        next_cycle();
        check("released_load", output_ALU, 16'h0245);

        // Randomized traffic; the per-cycle checker compares every cycle.
        for (int i = 0; i < 400; i++) begin
            logic [15:0] v[4];
            next_cycle();
            for (int k = 0; k < 4; k++) begin
                case ($urandom_range(0, 5))
                    0: v[k] = 16'h0000;
                    1: v[k] = 16'hFFFF;
                    2: v[k] = 16'h8000;
                    default: v[k] = 16'($urandom);
                endcase
            end
            drive(1'($urandom), 2'($urandom), 2'($urandom), 3'($urandom),
                  v[0], v[1], v[2], v[3]);
            if (i % 97 == 50) begin
                #2 reset = 1'b0;
                #1 reset = 1'b1;
            end
        end

        next_cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
